// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer widths from depth and Gray/binary conversion.
package fifo_pkg;

    // Widest pointer the conversion helpers support; callers cast to their own width.
    localparam int unsigned GRAY_MAX_W = 32;

    // RAM address width for a given depth (at least one bit).
    function automatic int unsigned addr_w_of(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer width including the wrap bit.
    function automatic int unsigned ptr_w_of(input int unsigned depth);
        return addr_w_of(depth) + 1;
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary; zero upper bits stay zero, so narrow pointers convert correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer bringing a Gray pointer into the read clock domain.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift chain; stage 0 samples the asynchronous pointer directly.
    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer controller for the async FIFO with integrated write-pointer sync.
module rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH       = 8,
    parameter  int unsigned SYNC_STAGES = 2,
    parameter  int unsigned AE_THRESH   = 1,
    localparam int unsigned ADDR_W      = addr_w_of(DEPTH),
    localparam int unsigned PTR_W       = ptr_w_of(DEPTH)
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic              r_en,
    input  logic [PTR_W-1:0]  gray_w_ptr_async,
    input  logic              underflow_clr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_fire,
    output logic [PTR_W-1:0]  gray_r_ptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [PTR_W-1:0]  level,
    output logic              underflow
);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rd_ptr_ctrl: DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("rd_ptr_ctrl: SYNC_STAGES must be >= 2");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("rd_ptr_ctrl: AE_THRESH must be below DEPTH");
    end

    logic [PTR_W-1:0] bin_r_ptr_q;
    logic [PTR_W-1:0] bin_r_ptr_d;
    logic [PTR_W-1:0] gray_r_ptr_q;
    logic [PTR_W-1:0] gray_r_ptr_d;
    logic             underflow_q;
    logic             underflow_d;

    logic [PTR_W-1:0] gray_w_sync;
    logic [PTR_W-1:0] bin_w_sync;
    logic [PTR_W-1:0] bin_r_inc;
    logic [PTR_W-1:0] level_c;
    logic             empty_c;
    logic             fire_c;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_w_sync (
        .rclk  (rclk),
        .reset (reset),
        .d_i   (gray_w_ptr_async),
        .q_o   (gray_w_sync)
    );

    // Status derived purely from registered pointers; only rd_fire sees r_en.
    always_comb begin
        bin_w_sync = PTR_W'(gray2bin(GRAY_MAX_W'(gray_w_sync)));
        level_c    = bin_w_sync - bin_r_ptr_q;
        empty_c    = (bin_r_ptr_q == bin_w_sync);
        fire_c     = r_en & ~empty_c;
    end

    // Next-state: advance both pointers on an accepted read, track underflow (set beats clear).
    always_comb begin
        bin_r_inc    = bin_r_ptr_q + PTR_W'(1);
        bin_r_ptr_d  = bin_r_ptr_q;
        gray_r_ptr_d = gray_r_ptr_q;
        underflow_d  = underflow_q;
        if (fire_c) begin
            bin_r_ptr_d  = bin_r_inc;
            gray_r_ptr_d = PTR_W'(bin2gray(GRAY_MAX_W'(bin_r_inc)));
        end
        if (underflow_clr) begin
            underflow_d = 1'b0;
        end
        if (r_en && empty_c) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and flag registers; reset takes priority over any read.
    always_ff @(posedge rclk) begin
        if (reset) begin
            bin_r_ptr_q  <= '0;
            gray_r_ptr_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            bin_r_ptr_q  <= bin_r_ptr_d;
            gray_r_ptr_q <= gray_r_ptr_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rd_addr      = bin_r_ptr_q[ADDR_W-1:0];
    assign rd_fire      = fire_c;
    assign gray_r_ptr   = gray_r_ptr_q;
    assign empty        = empty_c;
    assign level        = level_c;
    assign almost_empty = (level_c <= PTR_W'(AE_THRESH));
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Self-checking bench for rd_ptr_ctrl: cycle model plus read-address scoreboard.
module tb_rd_ptr_ctrl;

    localparam logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                         4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    logic       rclk = 1'b0;
    logic       reset;
    logic       r_en;
    logic       underflow_clr;
    logic [3:0] gray_w;
    logic [2:0] rd_addr;
    logic       rd_fire;
    logic [3:0] gray_r_ptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] level;
    logic       underflow;

    logic       r_en2;
    logic [3:0] gray_w2;
    logic [2:0] rd_addr2;
    logic       rd_fire2;
    logic [3:0] gray_r_ptr2;
    logic       empty2;
    logic       almost_empty2;
    logic [3:0] level2;
    logic       underflow2;

    always #5 rclk = ~rclk;

    rd_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
        .rclk             (rclk),
        .reset            (reset),
        .r_en             (r_en),
        .gray_w_ptr_async (gray_w),
        .underflow_clr    (underflow_clr),
        .rd_addr          (rd_addr),
        .rd_fire          (rd_fire),
        .gray_r_ptr       (gray_r_ptr),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .level            (level),
        .underflow        (underflow)
    );

    rd_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .AE_THRESH(2)) dut2 (
        .rclk             (rclk),
        .reset            (reset),
        .r_en             (r_en2),
        .gray_w_ptr_async (gray_w2),
        .underflow_clr    (underflow_clr),
        .rd_addr          (rd_addr2),
        .rd_fire          (rd_fire2),
        .gray_r_ptr       (gray_r_ptr2),
        .empty            (empty2),
        .almost_empty     (almost_empty2),
        .level            (level2),
        .underflow        (underflow2)
    );

    int         n_chk;
    int         n_pass;
    logic [3:0] m_r;
    logic [3:0] m_w;
    logic [3:0] m_s1;
    logic [3:0] w_bin;
    logic       m_uf;
    logic       last_fire;
    logic       last_rst;
    logic [3:0] last_gray;
    logic [2:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One read-clock cycle: drive inputs, compare against the model, then apply the edge to the model.
    task automatic cycle(input logic en, input logic clr, input logic rst);
        logic [3:0] lvl;
        logic       fire;
        r_en          = en;
        underflow_clr = clr;
        reset         = rst;
        gray_w        = GRAY[w_bin];
        #1;
        lvl  = m_w - m_r;
        fire = en && (lvl != '0);
        chk("level",        32'(level),        32'(lvl));
        chk("empty",        32'(empty),        32'(lvl == '0));
        chk("almost_empty", 32'(almost_empty), 32'(lvl <= 4'd1));
        chk("underflow",    32'(underflow),    32'(m_uf));
        chk("gray_r_ptr",   32'(gray_r_ptr),   32'(GRAY[m_r]));
        chk("rd_addr",      32'(rd_addr),      32'(m_r[2:0]));
        chk("rd_fire",      32'(rd_fire),      32'(fire));
        if (!last_rst)
            chk("gray_step", 32'($countones(gray_r_ptr ^ last_gray)), last_fire ? 32'd1 : 32'd0);
        if (fire) exp_q.push_back(m_r[2:0]);
        if (rd_fire) begin
            chk("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk("sb_rd_addr", 32'(rd_addr), 32'(exp_q.pop_front()));
        end
        last_gray = gray_r_ptr;
        last_fire = fire;
        last_rst  = rst;
        if (rst) begin
            m_r = '0; m_w = '0; m_s1 = '0; m_uf = 1'b0;
        end else begin
            if (fire) m_r = m_r + 4'd1;
            if (en && lvl == '0) m_uf = 1'b1;
            else if (clr)        m_uf = 1'b0;
            m_w  = m_s1;
            m_s1 = w_bin;
        end
        @(negedge rclk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        m_r = '0; m_w = '0; m_s1 = '0; w_bin = '0; m_uf = 1'b0;
        last_fire = 1'b0; last_rst = 1'b1; last_gray = '0;
        reset = 1'b1; r_en = 1'b0; underflow_clr = 1'b0; gray_w = '0;
        r_en2 = 1'b0; gray_w2 = '0;
        repeat (2) @(negedge rclk);

        // 1: reset values
        #1;
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_ae",    32'(almost_empty), 32'd1);
        chk("t1_level", 32'(level), 32'd0);
        chk("t1_addr",  32'(rd_addr), 32'd0);
        chk("t1_gray",  32'(gray_r_ptr), 32'd0);
        chk("t1_uf",    32'(underflow), 32'd0);
        chk("t1_fire",  32'(rd_fire), 32'd0);
        chk("t1_ae2",   32'(almost_empty2), 32'd1);

        // 2: write pointer to 5, synchronizer delay, drain five entries
        w_bin = 4'd5;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_level", 32'(level), 32'd5);
        chk("t2_empty", 32'(empty), 32'd0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_empty_end", 32'(empty), 32'd1);
        chk("t2_gray_end",  32'(gray_r_ptr), 32'h7);

        // 3: underflow set, hold, clear, set-beats-clear
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #1;
        chk("t3_uf",   32'(underflow), 32'd1);
        chk("t3_addr", 32'(rd_addr), 32'd5);
        cycle(1'b0, 1'b1, 1'b0);

        // 4: wrap through address 7->0 and pointer 15->0 with a legal writer
        w_bin = 4'd0;
        cycle(1'b0, 1'b0, 1'b1);
        w_bin = 4'd8;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        w_bin = 4'd9;
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        #1;
        chk("t4_gray9",  32'(gray_r_ptr), 32'hD);
        chk("t4_empty9", 32'(empty), 32'd1);
        chk("t4_addr9",  32'(rd_addr), 32'd1);
        for (int k = 0; k < 7; k++) begin
            w_bin = w_bin + 4'd1;
            cycle(1'b1, 1'b0, 1'b0);
        end
        repeat (10) cycle(1'b1, 1'b0, 1'b0);
        #1;
        chk("t4_wrap_gray", 32'(gray_r_ptr), 32'd0);
        chk("t4_wrap_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);

        // 6: reset mid-operation with r_en high, then resync
        w_bin = 4'd4;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        #1;
        chk("t6_level_pre", 32'(level), 32'd4);
        cycle(1'b1, 1'b0, 1'b1);
        #1;
        chk("t6_level_rst", 32'(level), 32'd0);
        chk("t6_addr_rst",  32'(rd_addr), 32'd0);
        chk("t6_empty_rst", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #1;
        chk("t6_level_post", 32'(level), 32'd4);
        cycle(1'b0, 1'b0, 1'b0);

        // 5: AE_THRESH=2 instance
        gray_w2 = GRAY[3];
        @(negedge rclk);
        @(negedge rclk);
        #1;
        chk("t5_level3", 32'(level2), 32'd3);
        chk("t5_ae3",    32'(almost_empty2), 32'd0);
        chk("t5_empty3", 32'(empty2), 32'd0);
        r_en2 = 1'b1;
        #1;
        chk("t5_fire",   32'(rd_fire2), 32'd1);
        chk("t5_addr",   32'(rd_addr2), 32'd0);
        @(negedge rclk);
        r_en2 = 1'b0;
        #1;
        chk("t5_level2", 32'(level2), 32'd2);
        chk("t5_ae2",    32'(almost_empty2), 32'd1);
        chk("t5_gray",   32'(gray_r_ptr2), 32'd1);
        chk("t5_uf",     32'(underflow2), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
